// File: rtl/uart_pkg.sv
// uart_pkg: shared state encodings and parity helper for uart_buffered.
// Words up to 9 bits are zero-extended before the parity reduction.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam int MAX_WORD = 9;

  function automatic logic parity_calc(
    input logic [MAX_WORD-1:0] d,
    input logic                odd
  );
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_buffered_if.sv
// uart_buffered_if: valid/ready word handshake bundle.
// master drives valid/data, slave answers with ready.
interface uart_buffered_if #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous TX word FIFO, registered full/empty flags.
// Push side is a slave handshake, pop side a master handshake.
module uart_fifo #(
  parameter int WORD_SIZE = 8,
  parameter int TX_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rstn,
  uart_buffered_if.slave   i_push,
  uart_buffered_if.master  o_pop
);
  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(TX_DEPTH);

  logic [WORD_SIZE-1:0] r_mem [TX_DEPTH];
  logic [AW-1:0]        r_wp;
  logic [AW-1:0]        r_rp;
  logic [AW:0]          r_cnt;
  logic                 r_full;
  logic                 r_empty;
  logic                 w_wr;
  logic                 w_rd;
  logic [AW:0]          w_cnt_nx;

  assign w_wr = i_push.valid && !r_full;
  assign w_rd = o_pop.ready && !r_empty;

  assign i_push.ready = !r_full;
  assign o_pop.valid  = !r_empty;
  assign o_pop.data   = r_mem[r_rp];

  assign w_cnt_nx = r_cnt
                  + {{AW{1'b0}}, w_wr}
                  - {{AW{1'b0}}, w_rd};

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_push.data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      r_cnt   <= w_cnt_nx;
      r_full  <= (w_cnt_nx == FULL_CNT);
      r_empty <= (w_cnt_nx == '0);
    end
  end

endmodule

// File: rtl/uart_buffered.sv
// uart_buffered: UART with TX FIFO and independent RX with valid/ready.
// Define UART_PARITY_EN to add a parity bit after the data bits.
module uart_buffered
  import uart_pkg::*;
#(
  parameter int WORD_SIZE   = 8,
  parameter int PULSE_WIDTH = 4,
  parameter int TX_DEPTH    = 4,
  parameter int PARITY_ODD  = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 send_valid,
  input  logic [WORD_SIZE-1:0] data_bits_tx,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [WORD_SIZE-1:0] data_bits_rx,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

`ifdef UART_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  localparam int CW = $clog2(PULSE_WIDTH);
  localparam int IW = $clog2(WORD_SIZE);
  localparam logic [CW-1:0] C_LAST = CW'(PULSE_WIDTH - 1);
  localparam logic [CW-1:0] C_HALF = CW'(PULSE_WIDTH / 2 - 1);
  localparam logic [IW-1:0] I_LAST = IW'(WORD_SIZE - 1);
  localparam logic          P_ODD  = 1'(PARITY_ODD);

  uart_buffered_if #(.W(WORD_SIZE)) w_push ();
  uart_buffered_if #(.W(WORD_SIZE)) w_pop ();

  logic w_tx_pop;

  assign w_push.valid = send_valid;
  assign w_push.data  = data_bits_tx;
  assign tx_ready     = w_push.ready;
  assign w_pop.ready  = w_tx_pop;

  uart_fifo #(
    .WORD_SIZE (WORD_SIZE),
    .TX_DEPTH  (TX_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .i_push (w_push),
    .o_pop  (w_pop)
  );

  tx_state_t            r_tx_st;
  tx_state_t            w_tx_nx;
  logic [CW-1:0]        r_tx_cnt;
  logic [IW-1:0]        r_tx_idx;
  logic [WORD_SIZE-1:0] r_tx_sh;
  logic                 r_tx_par;
  logic                 r_tx;
  logic                 w_tx_end;
  logic                 w_tx_bit;

  assign w_tx_end = (r_tx_cnt == C_LAST);
  assign tx       = r_tx;

  always_comb begin
    w_tx_nx  = r_tx_st;
    w_tx_pop = 1'b0;
    w_tx_bit = 1'b1;
    unique case (r_tx_st)
      TX_IDLE: begin
        if (w_pop.valid) begin
          w_tx_pop = 1'b1;
          w_tx_nx  = TX_START;
        end
      end
      TX_START: begin
        w_tx_bit = 1'b0;
        if (w_tx_end) w_tx_nx = TX_DATA;
      end
      TX_DATA: begin
        w_tx_bit = r_tx_sh[0];
        if (w_tx_end && r_tx_idx == I_LAST) begin
          if (PAR_EN) w_tx_nx = TX_PARITY;
          else        w_tx_nx = TX_STOP;
        end
      end
      TX_PARITY: begin
        w_tx_bit = r_tx_par;
        if (w_tx_end) w_tx_nx = TX_STOP;
      end
      TX_STOP: begin
        // chain straight into the next start bit when a word waits
        if (w_tx_end) begin
          if (w_pop.valid) begin
            w_tx_pop = 1'b1;
            w_tx_nx  = TX_START;
          end else begin
            w_tx_nx = TX_IDLE;
          end
        end
      end
      default: w_tx_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tx_st  <= TX_IDLE;
      r_tx_cnt <= '0;
      r_tx_idx <= '0;
      r_tx_sh  <= '0;
      r_tx_par <= 1'b0;
      r_tx     <= 1'b1;
    end else begin
      r_tx_st <= w_tx_nx;
      r_tx    <= w_tx_bit;
      if (w_tx_pop || r_tx_st == TX_IDLE || w_tx_end)
        r_tx_cnt <= '0;
      else
        r_tx_cnt <= r_tx_cnt + 1'b1;
      if (w_tx_pop) begin
        r_tx_sh  <= w_pop.data;
        r_tx_par <= parity_calc(MAX_WORD'(w_pop.data), P_ODD);
        r_tx_idx <= '0;
      end else if (r_tx_st == TX_DATA && w_tx_end) begin
        r_tx_sh  <= r_tx_sh >> 1;
        r_tx_idx <= r_tx_idx + 1'b1;
      end
    end
  end

  rx_state_t            r_rx_st;
  rx_state_t            w_rx_nx;
  logic                 r_rx_s1;
  logic                 r_rx_s2;
  logic                 r_rx_prev;
  logic [CW-1:0]        r_rx_cnt;
  logic [IW-1:0]        r_rx_idx;
  logic [WORD_SIZE-1:0] r_rx_sh;
  logic                 r_rx_par;
  logic [WORD_SIZE-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_ovr;
  logic                 r_ferr;
  logic                 r_perr;
  logic                 w_rx_end;
  logic                 w_bit_smp;
  logic                 w_par_smp;
  logic                 w_done;
  logic                 w_ferr;
  logic                 w_perr;
  logic                 w_hold;

  assign w_rx_end = (r_rx_cnt == C_LAST);
  assign w_hold   = r_rx_valid && !rx_ready;

  always_comb begin
    w_rx_nx   = r_rx_st;
    w_bit_smp = 1'b0;
    w_par_smp = 1'b0;
    w_done    = 1'b0;
    w_ferr    = 1'b0;
    w_perr    = 1'b0;
    unique case (r_rx_st)
      RX_IDLE: begin
        if (r_rx_prev && !r_rx_s2) w_rx_nx = RX_START;
      end
      RX_START: begin
        // mid start bit: high means a glitch, drop silently
        if (r_rx_cnt == C_HALF) begin
          if (r_rx_s2) w_rx_nx = RX_IDLE;
          else         w_rx_nx = RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_rx_end) begin
          w_bit_smp = 1'b1;
          if (r_rx_idx == I_LAST) begin
            if (PAR_EN) w_rx_nx = RX_PARITY;
            else        w_rx_nx = RX_STOP;
          end
        end
      end
      RX_PARITY: begin
        if (w_rx_end) begin
          w_par_smp = 1'b1;
          w_rx_nx   = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_rx_end) begin
          w_rx_nx = RX_IDLE;
          w_ferr  = !r_rx_s2;
          w_perr  = PAR_EN &&
                    (r_rx_par !=
                     parity_calc(MAX_WORD'(r_rx_sh), P_ODD));
          w_done  = !w_ferr && !w_perr;
        end
      end
      default: w_rx_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_st    <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_sh    <= '0;
      r_rx_par   <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_ovr      <= 1'b0;
      r_ferr     <= 1'b0;
      r_perr     <= 1'b0;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      r_rx_st   <= w_rx_nx;
      if (r_rx_st == RX_IDLE || w_rx_nx != r_rx_st || w_rx_end)
        r_rx_cnt <= '0;
      else
        r_rx_cnt <= r_rx_cnt + 1'b1;
      if (w_bit_smp) begin
        r_rx_sh  <= {r_rx_s2, r_rx_sh[WORD_SIZE-1:1]};
        r_rx_idx <= r_rx_idx + 1'b1;
      end else if (r_rx_st != RX_DATA) begin
        r_rx_idx <= '0;
      end
      if (w_par_smp) r_rx_par <= r_rx_s2;
      r_ferr <= w_ferr;
      r_perr <= w_perr;
      r_ovr  <= w_done && w_hold;
      // an unconsumed word wins over a newly completed one
      if (w_done && !w_hold) begin
        r_rx_data  <= r_rx_sh;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign data_bits_rx  = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign rx_overrun    = r_ovr;
  assign rx_frame_err  = r_ferr;
  assign rx_parity_err = PAR_EN ? r_perr : 1'b0;

endmodule

// File: doc/uart_buffered.md
UART_BUFFERED -- requirements
Module: uart_buffered

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 8, data bits per frame (5..9).
REQ-002 The block SHALL have parameter PULSE_WIDTH, default 4, clocks per bit (CLOCK_FREQ/BAUD, even, >=4).
REQ-003 The block SHALL have parameter TX_DEPTH, default 4, TX FIFO entries (power of 2, >=2).
REQ-004 The block SHALL have parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity (used only with UART_PARITY_EN).
REQ-005 The block SHALL have port clk, input, 1, sole clock.
REQ-006 The block SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port send_valid, input, 1, TX push request.
REQ-008 The block SHALL have port data_bits_tx, input, WORD_SIZE, TX word.
REQ-009 The block SHALL have port tx_ready, output, 1, TX FIFO not full.
REQ-010 The block SHALL have port tx, output, 1, serial out, registered.
REQ-011 The block SHALL have port rx, input, 1, serial in, asynchronous.
REQ-012 The block SHALL have port data_bits_rx, output, WORD_SIZE, received word.
REQ-013 The block SHALL have port rx_valid, output, 1, data_bits_rx holds an unconsumed word.
REQ-014 The block SHALL have port rx_ready, input, 1, consumer accepts word.
REQ-015 The block SHALL have port rx_overrun, output, 1, one-cycle pulse when a word is dropped.
REQ-016 The block SHALL have port rx_frame_err, output, 1, one-cycle pulse on bad stop bit.
REQ-017 The block SHALL have port rx_parity_err, output, 1, one-cycle pulse on parity mismatch.

Function
REQ-018 TX push SHALL occur on send_valid && tx_ready; push while full SHALL be ignored; tx_ready = !fifo_full.
REQ-019 TX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; each bit SHALL last exactly PULSE_WIDTH clocks; data SHALL be sent LSB first.
REQ-020 IDLE->START SHALL occur when the FIFO is non-empty, popping the head; tx SHALL go low 2 cycles after a push into an empty FIFO while idle.
REQ-021 STOP->START SHALL occur directly, with no idle bit, when the FIFO is non-empty at STOP end; otherwise STOP->IDLE.
REQ-022 Frame length SHALL be (2 + WORD_SIZE + P) * PULSE_WIDTH clocks, P = 1 with parity, else 0.
REQ-023 rx SHALL pass a 2-flop synchroniser; RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-024 RX SHALL leave IDLE on a synchronised falling edge and sample at PULSE_WIDTH/2 into the start bit; a high sample SHALL return to IDLE with no flags (false start).
REQ-025 RX SHALL sample subsequent bits every PULSE_WIDTH clocks at bit centre.
REQ-026 A low stop sample SHALL pulse rx_frame_err, discard the word, and return to IDLE.
REQ-027 A good stop SHALL load data_bits_rx and set rx_valid the next cycle.
REQ-028 rx_valid SHALL clear on rx_valid && rx_ready.
REQ-029 If a word completes while rx_valid && !rx_ready, the new word SHALL be dropped, the old word retained, and rx_overrun pulsed.
REQ-030 Completion in the same cycle as consumption SHALL load the new word, keep rx_valid high, and raise no overrun.
REQ-031 TX and RX SHALL operate fully independently and concurrently.

Reset
REQ-032 On rstn low, both FSMs SHALL go to IDLE, the FIFO SHALL empty, and counters SHALL clear.
REQ-033 Reset values SHALL be: tx=1, tx_ready=1, rx_valid=0, data_bits_rx=0, all error pulses 0, synchroniser flops=1.
REQ-034 Reset mid-frame SHALL abort the frame immediately with no completion or flags after release.

Configuration
REQ-035 With UART_PARITY_EN defined, a parity bit SHALL follow data (even: XOR of data; odd: inverted XOR); RX SHALL check it, pulse rx_parity_err alongside the stop sample, and discard the word.
REQ-036 Without UART_PARITY_EN, PARITY states SHALL be skipped and rx_parity_err SHALL be tied 0.

Structure
REQ-037 Package uart_pkg SHALL hold tx_state_t, rx_state_t enums and a parity_calc function.
REQ-038 The TX FIFO SHALL be sub-module uart_fifo (sync, registered full/empty, parameterised WORD_SIZE/TX_DEPTH).

Verification (WORD_SIZE=8, PULSE_WIDTH=4, TX_DEPTH=4)
REQ-039 Push 0xA5 with the block idle -> tx low 2 cycles later; bit sequence 0,1,0,1,0,0,1,0,1,1, 4 clocks each; 40 clocks total.
REQ-040 Loopback tx->rx, push 0x3C, 0xFF, 0x00 back-to-back with rx_ready=1 -> three rx_valid pulses with matching data and no gap between TX frames.
REQ-041 While frame 1 transmits, push 5 words -> tx_ready low after 4th stored word; 5th ignored; 4 further frames sent.
REQ-042 rx_ready=0, two frames 0x11, 0x22 -> data_bits_rx=0x11 held; rx_overrun pulse at second stop.
REQ-043 Drive stop bit 0 -> rx_frame_err pulse, rx_valid stays 0; 1-clock rx glitch -> no activity.
REQ-044 UART_PARITY_EN, even parity: send 0x07 -> parity bit 1; corrupt it on rx -> rx_parity_err pulse, word discarded; rstn low mid-frame -> tx=1 and IDLE.
